// File: rtl/pc_unit.sv
// Program counter with relative branch, absolute jump, call/return through a
// return-address stack, and pipeline stall. Drives the instruction-memory address.
module pc_unit #(
    parameter int unsigned             PC_WIDTH     = 16,
    parameter int unsigned             IMM_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0]     RESET_VECTOR = '0,
    parameter int unsigned             STACK_DEPTH  = 4,
    localparam int unsigned            CNT_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic                 i_branch_en,
    input  logic                 i_zero,
    input  logic [IMM_WIDTH-1:0] i_imm,
    input  logic                 i_jump_en,
    input  logic                 i_call_en,
    input  logic                 i_ret_en,
    input  logic [PC_WIDTH-1:0]  i_target,
    input  logic                 i_err_clr,
    output logic [PC_WIDTH-1:0]  o_pc_out,
    output logic [CNT_W-1:0]     o_stack_count,
    output logic                 o_stack_full,
    output logic                 o_stack_empty,
    output logic                 o_stack_err
);

    logic [PC_WIDTH-1:0] r_pc;
    logic [CNT_W-1:0]    r_count;
    logic                r_err;
    // Entry 0 is the top of stack; push shifts down, pop shifts up.
    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_imm_ext;
    logic [PC_WIDTH-1:0] w_pc_d;
    logic                w_push;
    logic                w_pop;
    logic                w_err_set;
    logic                w_full;
    logic                w_empty;

    assign w_pc_inc  = r_pc + PC_WIDTH'(1);
    assign w_imm_ext = PC_WIDTH'($signed(i_imm));
    assign w_full    = (r_count == CNT_W'(STACK_DEPTH));
    assign w_empty   = (r_count == '0);

    always_comb begin
        w_pc_d    = w_pc_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        if (i_stall) begin
            w_pc_d = r_pc;
        end else if (i_ret_en) begin
            if (!w_empty) begin
                w_pc_d = r_stack[0];
                w_pop  = 1'b1;
            end else begin
                w_err_set = 1'b1;
            end
        end else if (i_call_en) begin
            w_pc_d = i_target;
            if (!w_full) begin
                w_push = 1'b1;
            end else begin
                w_err_set = 1'b1;
            end
        end else if (i_jump_en) begin
            w_pc_d = i_target;
        end else if (i_branch_en && i_zero) begin
            w_pc_d = r_pc + w_imm_ext;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc    <= RESET_VECTOR;
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_pc  <= w_pc_d;
            r_err <= w_err_set | (r_err & ~i_err_clr);
            if (w_push) begin
                r_count    <= r_count + CNT_W'(1);
                r_stack[0] <= w_pc_inc;
                for (int i = 1; i < STACK_DEPTH; i++) begin
                    r_stack[i] <= r_stack[i-1];
                end
            end else if (w_pop) begin
                r_count <= r_count - CNT_W'(1);
                for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                    r_stack[i] <= r_stack[i+1];
                end
            end
        end
    end

    assign o_pc_out      = r_pc;
    assign o_stack_count = r_count;
    assign o_stack_full  = w_full;
    assign o_stack_empty = w_empty;
    assign o_stack_err   = r_err;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit at default parameters.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_en;
    logic        zero;
    logic [15:0] imm;
    logic        jump_en;
    logic        call_en;
    logic        ret_en;
    logic [15:0] target;
    logic        err_clr;
    logic [15:0] pc_out;
    logic [2:0]  stack_count;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_stall       (stall),
        .i_branch_en   (branch_en),
        .i_zero        (zero),
        .i_imm         (imm),
        .i_jump_en     (jump_en),
        .i_call_en     (call_en),
        .i_ret_en      (ret_en),
        .i_target      (target),
        .i_err_clr     (err_clr),
        .o_pc_out      (pc_out),
        .o_stack_count (stack_count),
        .o_stack_full  (stack_full),
        .o_stack_empty (stack_empty),
        .o_stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests, clock it, then sample 1ns after the edge.
    task automatic cyc(input logic r, input logic c, input logic j, input logic b,
                       input logic z, input logic [15:0] im, input logic [15:0] t,
                       input logic s, input logic clr);
        ret_en = r; call_en = c; jump_en = j; branch_en = b; zero = z;
        imm = im; target = t; stall = s; err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
    endtask

    task automatic stk(input string tag, input int cnt, input logic full,
                       input logic empty, input logic err);
        check({tag, ".count"}, 32'(stack_count), 32'(cnt));
        check({tag, ".full"},  32'(stack_full),  32'(full));
        check({tag, ".empty"}, 32'(stack_empty), 32'(empty));
        check({tag, ".err"},   32'(stack_err),   32'(err));
    endtask

    initial begin
        logic [15:0] exp_ret [4];
        exp_ret[0] = 16'h0401; exp_ret[1] = 16'h0301;
        exp_ret[2] = 16'h0201; exp_ret[3] = 16'h0022;

        rst_n = 1'b0;
        ret_en = 0; call_en = 0; jump_en = 0; branch_en = 0; zero = 0;
        imm = '0; target = '0; stall = 0; err_clr = 0;
        #12;
        check("reset.pc", 32'(pc_out), 32'h0);
        stk("reset", 0, 0, 1, 0);
        rst_n = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            idle();
            check($sformatf("free.pc%0d", i), 32'(pc_out), 32'(i));
        end
        stk("free", 0, 0, 1, 0);

        // Relative branch, taken and not taken
        cyc(0, 0, 1, 0, 0, 16'h0, 16'h0010, 0, 0);
        check("jump.pc", 32'(pc_out), 32'h0010);
        cyc(0, 0, 0, 1, 1, 16'hFFFC, 16'h0, 0, 0);
        check("br_taken.pc", 32'(pc_out), 32'h000C);
        cyc(0, 0, 1, 0, 0, 16'h0, 16'h0010, 0, 0);
        cyc(0, 0, 0, 1, 0, 16'hFFFC, 16'h0, 0, 0);
        check("br_not.pc", 32'(pc_out), 32'h0011);

        // Single call / return
        cyc(0, 0, 1, 0, 0, 16'h0, 16'h0020, 0, 0);
        cyc(0, 1, 0, 0, 0, 16'h0, 16'h0100, 0, 0);
        check("call.pc", 32'(pc_out), 32'h0100);
        stk("call", 1, 0, 0, 0);
        idle();
        idle();
        check("inc2.pc", 32'(pc_out), 32'h0102);
        cyc(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        check("ret.pc", 32'(pc_out), 32'h0021);
        stk("ret", 0, 0, 1, 0);

        // Nested calls up to and past the stack depth
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 0, 16'h0, 16'((i + 2) << 8), 0, 0);
        end
        check("nest4.pc", 32'(pc_out), 32'h0500);
        stk("nest4", 4, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 16'h0, 16'h0600, 0, 0);
        check("overflow.pc", 32'(pc_out), 32'h0600);
        stk("overflow", 4, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
            check($sformatf("unwind%0d.pc", i), 32'(pc_out), 32'(exp_ret[i]));
        end
        stk("unwind", 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        check("underflow.pc", 32'(pc_out), 32'h0023);
        stk("underflow", 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 1);
        check("errclr.pc", 32'(pc_out), 32'h0024);
        check("errclr.err", 32'(stack_err), 32'h0);
        // Set and clear in the same cycle: set wins
        cyc(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 1);
        check("setwins.pc", 32'(pc_out), 32'h0025);
        check("setwins.err", 32'(stack_err), 32'h1);
        cyc(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 1);
        check("errclr2.err", 32'(stack_err), 32'h0);

        // Priority: ret beats call and jump
        cyc(0, 1, 0, 0, 0, 16'h0, 16'h0700, 0, 0);
        stk("prio_setup", 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 1, 16'h0004, 16'h0900, 0, 0);
        check("prio.pc", 32'(pc_out), 32'h0027);
        stk("prio", 0, 0, 1, 0);

        // Stall holds everything, ignores requests
        cyc(0, 1, 0, 0, 0, 16'h0, 16'h0800, 0, 0);
        cyc(1, 1, 1, 1, 1, 16'h0004, 16'h0900, 1, 0);
        check("stall.pc", 32'(pc_out), 32'h0800);
        stk("stall", 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        check("post_stall.pc", 32'(pc_out), 32'h0028);

        // Wrap-around
        cyc(0, 0, 1, 0, 0, 16'h0, 16'hFFFF, 0, 0);
        idle();
        check("wrap.pc", 32'(pc_out), 32'h0000);
        cyc(0, 0, 1, 0, 0, 16'h0, 16'hFFFF, 0, 0);
        cyc(0, 1, 0, 0, 0, 16'h0, 16'h1234, 0, 0);
        cyc(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        check("wrap_push.pc", 32'(pc_out), 32'h0000);

        // Asynchronous reset mid-cycle with a call pending
        cyc(0, 1, 0, 0, 0, 16'h0, 16'h1234, 0, 0);
        check("pre_rst.pc", 32'(pc_out), 32'h1234);
        call_en = 1'b1; target = 16'h0055;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.pc", 32'(pc_out), 32'h0000);
        stk("async_rst", 0, 0, 1, 0);
        @(negedge clk);
        call_en = 1'b0;
        rst_n = 1'b1;
        idle();
        check("rst_release.pc", 32'(pc_out), 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program counter with relative branch, absolute jump, call/return via an internal return-address stack, and pipeline stall. Sits at the front of the fetch path and drives the instruction-memory address. Supersedes the fixed 8-bit increment/branch counter. Adds configurable width, reset vector, stall hold and stack error reporting.

Parameters:
PC_WIDTH, 16, width of pc_out and all PC arithmetic
IMM_WIDTH, 16, width of signed branch offset imm (IMM_WIDTH <= PC_WIDTH)
RESET_VECTOR, 0, pc_out value on reset
STACK_DEPTH, 4, return-address stack entries (>= 1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
stall  input  1  hold PC and stack this cycle
branch_en  input  1  conditional relative branch request
zero  input  1  ALU zero flag; branch taken when branch_en && zero
imm  input  IMM_WIDTH  signed two's-complement branch offset
jump_en  input  1  absolute jump to target
call_en  input  1  push return address, jump to target
ret_en  input  1  pop return address into PC
target  input  PC_WIDTH  absolute jump/call destination
err_clr  input  1  clears stack_err
pc_out  output  PC_WIDTH  current PC (registered)
stack_count  output  clog2(STACK_DEPTH+1)  entries in use
stack_full  output  1  stack_count == STACK_DEPTH
stack_empty  output  1  stack_count == 0
stack_err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately): pc_out=RESET_VECTOR, stack_count=0, stack_empty=1, stack_full=0, stack_err=0; stack contents don't-care.
- On release, first rising edge performs a normal update.
- stall=1: pc_out, stack, stack_count held; all requests ignored; err_clr still honoured.
- stall=0, one action per cycle, priority: ret_en > call_en > jump_en > taken branch > increment.
  - ret: stack non-empty -> pc_out <= top entry, stack_count-1. Empty -> pc_out <= pc_out+1, stack_err <= 1.
  - call: not full -> push pc_out+1, stack_count+1, pc_out <= target. Full -> pc_out <= target, push dropped, stack unchanged, stack_err <= 1.
  - jump: pc_out <= target.
  - branch taken (branch_en && zero): pc_out <= pc_out + sign_extend(imm).
  - branch_en && !zero, or no request: pc_out <= pc_out + 1.
- Arithmetic modulo 2^PC_WIDTH; wrap-around silent, no flag (all-ones + 1 -> 0).
- Stack is LIFO; pushed value is pc_out+1 computed modulo 2^PC_WIDTH.
- Lower-priority requests asserted together with a higher one are discarded, not queued.
- stack_err sticky; cleared by err_clr. Same-cycle set and clear: set wins.
- stack_full/stack_empty/stack_count combinational from registered count; valid same cycle as pc_out.
- Latency: every accepted request visible on pc_out one cycle after the edge that samples it.
- Reset asserted mid-cycle overrides everything, including an in-flight call/ret.

Test Plan:
- Reset then 3 free-running cycles, defaults -> pc_out 0,1,2,3; stack_empty=1, stack_err=0.
- From pc_out=0x0010: branch_en=1, zero=1, imm=0xFFFC -> pc_out=0x000C; repeat with zero=0 -> 0x0011.
- pc_out=0x0020, call_en, target=0x0100 -> pc_out=0x0100, stack_count=1; two increments then ret_en -> pc_out=0x0021, stack_empty=1.
- Five nested calls, STACK_DEPTH=4 -> fifth call still jumps to target, stack_full=1, stack_err=1; four rets return in reverse order; fifth ret on empty -> pc_out+1, stack_err stays 1; err_clr -> 0.
- call_en, ret_en, jump_en together with stack_count=1 -> ret taken, stack_count=0; with stall=1 same inputs -> pc_out and stack_count unchanged.
- pc_out=0xFFFF, no request -> 0x0000; rst pulsed low mid-cycle with call_en asserted -> pc_out=RESET_VECTOR immediately, stack_count=0.
